// File: rtl/stage_id_pkg.sv
// rtl/stage_id_pkg.sv - shared decode constants, ALU codes and stage state type
package stage_id_pkg;

  // Base opcodes handled by this stage
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam int ALUOP_W  = 4;
  localparam int ALUSEL_W = 3;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 4'd0;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = 4'd1;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP  = 4'd2;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 4'd3;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 4'd4;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 4'd5;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 4'd6;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 4'd7;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 4'd8;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 4'd9;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 4'd10;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'd0;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'd1;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'd2;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'd3;
  localparam logic [ALUSEL_W-1:0] EXE_RES_CMP   = 3'd4;

  typedef struct packed {
    logic [ALUOP_W-1:0]  op;
    logic [ALUSEL_W-1:0] sel;
  } alu_ctrl_t;

  typedef enum logic {ST_EMPTY, ST_FULL} stage_state_e;

  // alt selects SUB/SRA; callers pass 0 where inst[30] is an immediate bit
  function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3, input logic alt);
    alu_ctrl_t c;
    c.op  = EXE_NOP_OP;
    c.sel = EXE_RES_NOP;
    case (funct3)
      FUNCT3_ADD_SUB: begin c.op = alt ? EXE_SUB_OP : EXE_ADD_OP; c.sel = EXE_RES_ARITH; end
      FUNCT3_SLL:     begin c.op = EXE_SLL_OP;  c.sel = EXE_RES_SHIFT; end
      FUNCT3_SLT:     begin c.op = EXE_SLT_OP;  c.sel = EXE_RES_CMP;   end
      FUNCT3_SLTU:    begin c.op = EXE_SLTU_OP; c.sel = EXE_RES_CMP;   end
      FUNCT3_XOR:     begin c.op = EXE_XOR_OP;  c.sel = EXE_RES_LOGIC; end
      FUNCT3_SRL_SRA: begin c.op = alt ? EXE_SRA_OP : EXE_SRL_OP; c.sel = EXE_RES_SHIFT; end
      FUNCT3_OR:      begin c.op = EXE_OR_OP;   c.sel = EXE_RES_LOGIC; end
      default:        begin c.op = EXE_AND_OP;  c.sel = EXE_RES_LOGIC; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stage_id_pipe_fwd_mux.sv
// rtl/stage_id_pipe_fwd_mux.sv - priority forwarding select for one source operand
module id_fwd_mux #(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic [RADDR_W-1:0]           raddr,
  input  logic [XLEN-1:0]              reg_data,
  input  logic [FWD_PORTS-1:0]         fwd_we,
  input  logic [FWD_PORTS*RADDR_W-1:0] fwd_waddr,
  input  logic [FWD_PORTS*XLEN-1:0]    fwd_wdata,
  output logic [XLEN-1:0]              data
);

  // Walk oldest to youngest so the lowest matching index overrides; x0 is hardwired zero
  always_comb begin
    data = reg_data;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[i*RADDR_W +: RADDR_W] == raddr)) begin
        data = fwd_wdata[i*XLEN +: XLEN];
      end
    end
    if (raddr == '0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - RV32I decode stage with forwarding, load-use stall and output register (option: STAGE_ID_ILLEGAL_FLAG_EN)
module stage_id_pipe
  import stage_id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RADDR_W   = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [31:0]                  in_inst,
  output logic                         re1,
  output logic                         re2,
  output logic [RADDR_W-1:0]           reg_addr1,
  output logic [RADDR_W-1:0]           reg_addr2,
  input  logic [XLEN-1:0]              reg_data1,
  input  logic [XLEN-1:0]              reg_data2,
  input  logic [FWD_PORTS-1:0]         fwd_we,
  input  logic [FWD_PORTS*RADDR_W-1:0] fwd_waddr,
  input  logic [FWD_PORTS*XLEN-1:0]    fwd_wdata,
  input  logic                         ex_load,
  input  logic [RADDR_W-1:0]           ex_load_rd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ALUOP_W-1:0]           out_aluop,
  output logic [ALUSEL_W-1:0]          out_alusel,
  output logic [XLEN-1:0]              out_opv1,
  output logic [XLEN-1:0]              out_opv2,
  output logic                         out_we,
  output logic [RADDR_W-1:0]           out_waddr,
  output logic [XLEN-1:0]              out_pc,
  output logic                         out_illegal
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0]    imm_i;
  logic [XLEN-1:0]    imm_u;
  logic [XLEN-1:0]    shamt;
  logic [XLEN-1:0]    fwd_data1;
  logic [XLEN-1:0]    fwd_data2;

  logic               dec_legal;
  alu_ctrl_t          dec_ctrl;
  logic [XLEN-1:0]    dec_opv1;
  logic [XLEN-1:0]    dec_opv2;
  logic               dec_we;
  logic [RADDR_W-1:0] dec_waddr;

  logic               hazard;
  logic               load;
  stage_state_e       state_q;
  stage_state_e       state_d;

  assign opcode    = in_inst[6:0];
  assign funct3    = in_inst[14:12];
  assign funct7    = in_inst[31:25];
  assign rd        = in_inst[11:7];
  assign reg_addr1 = in_inst[19:15];
  assign reg_addr2 = in_inst[24:20];
  assign imm_i     = XLEN'($signed(in_inst[31:20]));
  assign imm_u     = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign shamt     = XLEN'(in_inst[24:20]);

  id_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_PORTS(FWD_PORTS)) u_fwd1 (
    .raddr     (reg_addr1),
    .reg_data  (reg_data1),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .data      (fwd_data1)
  );

  id_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_PORTS(FWD_PORTS)) u_fwd2 (
    .raddr     (reg_addr2),
    .reg_data  (reg_data2),
    .fwd_we    (fwd_we),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .data      (fwd_data2)
  );

  // Decode the incoming word; anything not legal collapses to a NOP with no register reads
  always_comb begin
    dec_legal = 1'b0;
    re1       = 1'b0;
    re2       = 1'b0;
    dec_ctrl  = '{op: EXE_ADD_OP, sel: EXE_RES_ARITH};
    dec_opv1  = '0;
    dec_opv2  = '0;
    case (opcode)
      OPC_OP_IMM: begin
        re1      = 1'b1;
        dec_opv1 = fwd_data1;
        dec_ctrl = alu_decode(funct3, (funct3 == FUNCT3_SRL_SRA) && in_inst[30]);
        if (funct3 == FUNCT3_SLL) begin
          dec_legal = (funct7 == FUNCT7_BASE);
          dec_opv2  = shamt;
        end else if (funct3 == FUNCT3_SRL_SRA) begin
          dec_legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          dec_opv2  = shamt;
        end else begin
          dec_legal = 1'b1;
          dec_opv2  = imm_i;
        end
      end
      OPC_OP: begin
        re1      = 1'b1;
        re2      = 1'b1;
        dec_opv1 = fwd_data1;
        dec_opv2 = fwd_data2;
        dec_ctrl = alu_decode(funct3, in_inst[30]);
        if ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA)) begin
          dec_legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
        end else begin
          dec_legal = (funct7 == FUNCT7_BASE);
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_opv1  = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_opv1  = in_pc;
        dec_opv2  = imm_u;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
    if (!dec_legal) begin
      re1      = 1'b0;
      re2      = 1'b0;
      dec_ctrl = '{op: EXE_NOP_OP, sel: EXE_RES_NOP};
      dec_opv1 = '0;
      dec_opv2 = '0;
    end
    dec_we    = dec_legal;
    dec_waddr = dec_legal ? rd : '0;
  end

  assign hazard = ex_load && (ex_load_rd != '0) &&
                  ((re1 && (reg_addr1 == ex_load_rd)) || (re2 && (reg_addr2 == ex_load_rd)));
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign load      = in_valid && in_ready && !flush;
  assign out_valid = (state_q == ST_FULL);

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush wins over capture; a consumed bundle with nothing new leaves a bubble
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (load) begin
      state_d = ST_FULL;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Decoded bundle register, only written on capture so it holds while EX stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_aluop  <= '0;
      out_alusel <= '0;
      out_opv1   <= '0;
      out_opv2   <= '0;
      out_we     <= 1'b0;
      out_waddr  <= '0;
      out_pc     <= '0;
    end else if (load) begin
      out_aluop  <= dec_ctrl.op;
      out_alusel <= dec_ctrl.sel;
      out_opv1   <= dec_opv1;
      out_opv2   <= dec_opv2;
      out_we     <= dec_we;
      out_waddr  <= dec_waddr;
      out_pc     <= in_pc;
    end
  end

`ifdef STAGE_ID_ILLEGAL_FLAG_EN
  logic illegal_q;

  // Illegal flag travels with the bundle it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (load) begin
      illegal_q <= !dec_legal;
    end
  end

  assign out_illegal = illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - scoreboard bench for stage_id_pipe
module tb_stage_id_pipe;
  import stage_id_pkg::*;

`ifdef STAGE_ID_ILLEGAL_FLAG_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [31:0]         opv1;
    logic [31:0]         opv2;
    logic                we;
    logic [4:0]          waddr;
    logic [31:0]         pc;
    logic                illegal;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        re1, re2;
  logic [4:0]  reg_addr1, reg_addr2;
  logic [31:0] reg_data1, reg_data2;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        ex_load;
  logic [4:0]  ex_load_rd;
  logic        out_valid;
  logic        out_ready;
  logic [ALUOP_W-1:0]  out_aluop;
  logic [ALUSEL_W-1:0] out_alusel;
  logic [31:0] out_opv1, out_opv2;
  logic        out_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;
  bundle_t exp_q[$];
  bundle_t discard;

  stage_id_pipe #(.XLEN(32), .RADDR_W(5), .FWD_PORTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .re1(re1), .re2(re2), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .reg_data1(reg_data1), .reg_data2(reg_data2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .ex_load(ex_load), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_opv1(out_opv1), .out_opv2(out_opv2),
    .out_we(out_we), .out_waddr(out_waddr), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic bundle_t mk(input logic [ALUOP_W-1:0] op, input logic [ALUSEL_W-1:0] sel,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [4:0] wa, input logic [31:0] pc);
    bundle_t b;
    b.aluop = op; b.alusel = sel; b.opv1 = v1; b.opv2 = v2;
    b.we = 1'b1; b.waddr = wa; b.pc = pc; b.illegal = 1'b0;
    return b;
  endfunction

  function automatic bundle_t mk_nop(input logic [31:0] pc);
    bundle_t b;
    b = '0;
    b.aluop = EXE_NOP_OP; b.alusel = EXE_RES_NOP; b.pc = pc; b.illegal = ILL_EXP;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input bundle_t e);
    bit ok;
    ok = 1'b0;
    in_pc = pc;
    in_inst = inst;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: pc %h not accepted within 20 cycles", pc);
    end
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the output side is compared against the scoreboard head
  always @(negedge clk) begin
    bundle_t got;
    bundle_t e;
    if (rst_n && out_valid && out_ready) begin
      got = '{aluop: out_aluop, alusel: out_alusel, opv1: out_opv1, opv2: out_opv2,
              we: out_we, waddr: out_waddr, pc: out_pc, illegal: out_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bundle_unexpected: got pc %h with no expected entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL bundle pc=%h: got op=%h sel=%h v1=%h v2=%h we=%b wa=%0d ill=%b expected op=%h sel=%h v1=%h v2=%h we=%b wa=%0d ill=%b",
                   e.pc, got.aluop, got.alusel, got.opv1, got.opv2, got.we, got.waddr, got.illegal,
                   e.aluop, e.alusel, e.opv1, e.opv2, e.we, e.waddr, e.illegal);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    reg_data1 = '0; reg_data2 = '0; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
    ex_load = 1'b0; ex_load_rd = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_opv1", out_opv1, 32'h0);
    check("reset_we", {31'b0, out_we}, 32'h0);
    check("reset_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'h1);

    // ADDI x1,x0,-5: x0 ignores regfile data
    reg_data1 = 32'h9999_9999;
    issue(32'h0, 32'hFFB0_0093, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'h0, 32'hFFFF_FFFB, 5'd1, 32'h0));

    // ADD x3,x1,x2: port 0 beats port 1 on rs1, rs2 from regfile
    reg_data1 = 32'hAAAA; reg_data2 = 32'h33;
    fwd_we = 2'b11; fwd_waddr = {5'd1, 5'd1}; fwd_wdata = {32'h22, 32'h11};
    issue(32'h4, 32'h0020_81B3, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'h11, 32'h33, 5'd3, 32'h4));

    // Only port 1 active, matching rs2
    fwd_we = 2'b10; fwd_waddr = {5'd2, 5'd1}; fwd_wdata = {32'h77, 32'h11};
    issue(32'h8, 32'h0020_81B3, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'hAAAA, 32'h77, 5'd3, 32'h8));

    // Forwarding to x0 must not leak
    fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd0}; fwd_wdata = {32'h0, 32'hDEAD};
    reg_data1 = 32'h5555; reg_data2 = 32'h5555;
    issue(32'hC, 32'h0000_01B3, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'h0, 32'h0, 5'd3, 32'hC));
    fwd_we = 2'b00;

    // Load-use hazard on rs1 then rs2, released by a load to x0
    reg_data1 = 32'h100; reg_data2 = 32'h30;
    ex_load = 1'b1; ex_load_rd = 5'd5;
    in_pc = 32'h10; in_inst = 32'h4072_8333; in_valid = 1'b1;
    @(negedge clk);
    check("hazard_rs1_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    check("hazard_bubble_out_valid", {31'b0, out_valid}, 32'h0);
    check("hazard_rs1_in_ready_hold", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    ex_load_rd = 5'd7;
    @(negedge clk);
    check("hazard_rs2_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    ex_load_rd = 5'd0;
    issue(32'h10, 32'h4072_8333, mk(EXE_SUB_OP, EXE_RES_ARITH, 32'h100, 32'h30, 5'd6, 32'h10));
    ex_load = 1'b0;

    // SRAI x11,x3,7: shamt zero-extended, funct7 selects arithmetic shift
    reg_data1 = 32'h8000_0000;
    issue(32'h14, 32'h4071_D593, mk(EXE_SRA_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'h7, 5'd11, 32'h14));
    drain();

    // Backpressure hold then flush
    out_ready = 1'b0;
    reg_data1 = 32'h1234;
    issue(32'h18, 32'h8000_C413, mk(EXE_XOR_OP, EXE_RES_LOGIC, 32'h1234, 32'hFFFF_F800, 5'd8, 32'h18));
    in_pc = 32'h1C; in_inst = 32'hABCD_E537; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_out_valid", {31'b0, out_valid}, 32'h1);
      check("hold_in_ready", {31'b0, in_ready}, 32'h0);
      check("hold_opv2", out_opv2, 32'hFFFF_F800);
      check("hold_pc", out_pc, 32'h18);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("flush_kills_held", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_blocks_capture", {31'b0, out_valid}, 32'h0);
    discard = exp_q.pop_front();
    issue(32'h1C, 32'hABCD_E537, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'hABCD_E000, 32'h0, 5'd10, 32'h1C));

    // AUIPC, unknown opcode, bad-funct7 SLLI
    issue(32'h100, 32'h1234_5217, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'h100, 32'h1234_5000, 5'd4, 32'h100));
    issue(32'h104, 32'h0000_007F, mk_nop(32'h104));
    issue(32'h108, 32'h0200_9093, mk_nop(32'h108));
    drain();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    issue(32'h200, 32'hFFB0_0093, mk(EXE_ADD_OP, EXE_RES_ARITH, 32'h0, 32'hFFFF_FFFB, 5'd1, 32'h200));
    discard = exp_q.pop_front();
    @(posedge clk);
    #2;
    check("pre_reset_full", {31'b0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("async_reset_opv2", out_opv2, 32'h0);
    check("async_reset_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drain();
    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
